logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised successor to the 16-bit NOT gate.
- Performs a selectable bitwise operation on two WIDTH-bit operands and buffers results in a DEPTH-entry output FIFO behind a valid/ready handshake.
- Serves as the bitwise front end of the ALU datapath and as a streaming logic engine between the CPU and memory-mapped peripherals.

Parameters:
WIDTH, 16, operand/result width in bits (>=1)
DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  unit can accept an operation this cycle
in_op  input  3  operation select
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored by NOT and PASS)
out_valid  output  1  FIFO head holds a result
out_ready  input  1  consumer takes head this cycle
out_data  output  WIDTH  FIFO head result
out_level  output  $clog2(DEPTH)+1  FIFO occupancy
done_count  output  16  results popped since reset, wraps 0xFFFF->0x0000

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- in_op encoding:
  - 0 NOT a
  - 1 a AND b
  - 2 a OR b
  - 3 a XOR b
  - 4 a NAND b
  - 5 a NOR b
  - 6 a XNOR b
  - 7 PASS a
- Result is computed combinationally from in_a/in_b/in_op and written into the FIFO tail on the accepting edge.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (out_level != DEPTH). There is no combinational path from out_ready to in_ready. A full FIFO deasserts in_ready even in a pop cycle; in_ready reasserts the cycle after the pop.
- out_valid = (out_level != 0). out_data = head entry. When out_level==0, out_data holds its last value (0 after reset).
- Latency: a push into an empty FIFO appears on out_data/out_valid the next cycle. Throughput is one result per cycle when out_ready is held high.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged; head advances; new entry goes to tail.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked in out_level; full and empty are never inferred from pointer equality alone.
- Pop with out_level==0 is impossible because out_valid is low. Push when full is impossible because in_ready is low. Both are ignored by construction.
- done_count increments by 1 on each pop and wraps modulo 2^16.
- Reset (including mid-stream): pointers=0, out_level=0, out_valid=0, in_ready=1 the cycle after reset deasserts, out_data=0, done_count=0. Buffered results are discarded. Inputs in the reset cycle are not accepted.
- While reset is high, in_ready=0.
- Handshake rule: a producer holding in_valid high with in_ready low must keep in_op/in_a/in_b stable. The unit samples them only on the accepting edge.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN
- Defined:
  - Adds outputs out_zr (1 bit) and out_ng (1 bit), stored per FIFO entry alongside the result and presented with the head.
  - out_zr = (result == 0).
  - out_ng = result[WIDTH-1].
  - Both are 0 after reset and when the FIFO is empty.
  - Matches Hack ALU flag semantics.
- Undefined: the ports do not exist and no flag storage is generated. All other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_level=0, out_data=0x0000, done_count=0.
- WIDTH=16, out_ready=1, push op=0 a=0x0000, then 0xFFFF, 0xAAAA, 0x3CC3, 0x1234 on consecutive cycles -> out_data one cycle later: 0xFFFF, 0x0000, 0x5555, 0xC33C, 0xEDCB; done_count=5.
- out_ready=0, push op=1 (0xF0F0,0xFF00) and op=3 (0xF0F0,0xFF00) -> out_level=2, in_ready=0. Hold a third push valid, then raise out_ready -> results 0xF000, then 0x0FF0. Third push is accepted the cycle after the first pop.
- Continuous push of ops 2,4,5,6,7 with a=0x00FF, b=0x0F0F and out_ready toggling 1,0 -> in-order results 0x0FFF, 0xFFF0, 0xF000, 0xF00F, 0x00FF; no loss or duplication; out_level never exceeds 2.
- Fill FIFO, assert reset for one cycle mid-stream -> out_valid=0, out_level=0, done_count=0 next cycle; buffered results are never emitted.
- With LOGIC_UNIT_FLAGS_EN: op=1 a=0x0F0F b=0xF0F0 -> out_data 0x0000, out_zr=1, out_ng=0. Then op=0 a=0x0001 -> out_data 0xFFFE, out_zr=0, out_ng=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Selectable bitwise logic unit feeding a DEPTH-entry result FIFO behind valid/ready.
// Optional LOGIC_UNIT_FLAGS_EN adds per-entry zero/negative flags (out_zr, out_ng).
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] out_level,
  output logic [15:0]            done_count
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic                   out_zr,
  output logic                   out_ng
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [15:0]      done_q, done_d;
  logic [WIDTH-1:0] res;
  logic             push, pop;

  always_comb begin
    res = in_a;
    unique case (op_e'(in_op))
      OP_NOT:  res = ~in_a;
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      OP_XNOR: res = ~(in_a ^ in_b);
      OP_PASS: res = in_a;
      default: res = in_a;
    endcase
  end

  assign in_ready   = ~reset & (level_q != LW'(DEPTH));
  assign out_valid  = (level_q != '0);
  assign out_data   = head_q;
  assign out_level  = level_q;
  assign done_count = done_q;

  // The head is kept in its own register so out_data holds the last result
  // once the FIFO drains; it is loaded with whatever sits at the next read slot,
  // bypassing the array when that slot is being written this same edge.
  always_comb begin
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    done_d   = done_q + 16'(pop);
    head_d   = head_q;
    if (level_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? res : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res;
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  // Flags are {ng, zr}, stored alongside each result.
  logic [1:0] flg_q [DEPTH];
  logic [1:0] res_flg, hflg_q, hflg_d;

  assign res_flg = {res[WIDTH-1], (res == '0)};
  assign out_ng  = out_valid & hflg_q[1];
  assign out_zr  = out_valid & hflg_q[0];

  always_comb begin
    hflg_d = hflg_q;
    if (level_d != '0) begin
      hflg_d = (push && (wr_ptr_q == rd_ptr_d)) ? res_flg : flg_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hflg_q <= '0;
    else       hflg_q <= hflg_d;
  end

  always_ff @(posedge clk) begin
    if (push) flg_q[wr_ptr_q] <= res_flg;
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_logic_unit_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_level;
  logic [15:0] done_count;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        out_zr;
  logic        out_ng;
`endif

  logic_unit_pipe #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_level  (out_level),
    .done_count (done_count)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .out_zr     (out_zr),
    .out_ng     (out_ng)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  logic [15:0] mq[$];
  logic [15:0] popped[$];
  logic [15:0] mlast;
  logic [15:0] mdone;
  logic        acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // One clock cycle with current inputs; checks handshake before the edge and state after.
  task automatic step();
    logic        exp_rdy, exp_vld, do_push, do_pop;
    logic [15:0] r;
    #1;
    exp_rdy = !reset && (mq.size() != 2);
    exp_vld = (mq.size() != 0);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid_pre", out_valid, exp_vld);
    do_push = in_valid && exp_rdy;
    do_pop  = exp_vld && out_ready && !reset;
    if (do_pop) popped.push_back(out_data);
    r   = ref_op(in_op, in_a, in_b);
    acc = do_push;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      mdone = '0;
      mlast = '0;
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        mdone = mdone + 16'd1;
      end
      if (do_push) mq.push_back(r);
      if (mq.size() != 0) mlast = mq[0];
    end
    check_eq("out_level", out_level, 32'(mq.size()));
    check_eq("out_valid", out_valid, (mq.size() != 0));
    check_eq("out_data", out_data, mlast);
    check_eq("done_count", done_count, mdone);
`ifdef LOGIC_UNIT_FLAGS_EN
    check_eq("out_zr", out_zr, (mq.size() != 0) && (mlast == 16'h0000));
    check_eq("out_ng", out_ng, (mq.size() != 0) && mlast[15]);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a1[5];
    logic [15:0] e1[5];
    int          ops3[5];
    logic [15:0] e3[5];
    int          tries;
    logic        pending;

    a1   = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
    e1   = '{16'hFFFF, 16'h0000, 16'h5555, 16'hC33C, 16'hEDCB};
    ops3 = '{2, 4, 5, 6, 7};
    e3   = '{16'h0FFF, 16'hFFF0, 16'hF000, 16'hF00F, 16'h00FF};

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    mlast = '0; mdone = '0; acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Reset then idle
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_level", out_level, 0);
    check_eq("rst_out_data", out_data, 16'h0000);
    check_eq("rst_done", done_count, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // NOT stream at full throughput
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_b = 16'h5A5A;
    for (int k = 0; k < 5; k++) begin
      in_a = a1[k];
      step();
      check_eq("not_seq", out_data, e1[k]);
    end
    in_valid = 1'b0;
    step();
    check_eq("not_done", done_count, 16'd5);

    // Fill, back-pressure, then drain with a held third push
    out_ready = 1'b0; in_valid = 1'b1;
    in_op = 3'd1; in_a = 16'hF0F0; in_b = 16'hFF00; step();
    in_op = 3'd3; step();
    check_eq("full_level", out_level, 2);
    check_eq("full_in_ready", in_ready, 0);
    in_op = 3'd2; in_a = 16'h1234; in_b = 16'h0000; step();
    check_eq("full_head", out_data, 16'hF000);
    out_ready = 1'b1; step();
    check_eq("pop1_acc", acc, 0);
    check_eq("pop1_head", out_data, 16'h0FF0);
    step();
    check_eq("third_head", out_data, 16'h1234);
    check_eq("third_level", out_level, 1);
    in_valid = 1'b0; step();

    // Mixed ops with toggling out_ready
    popped.delete();
    in_a = 16'h00FF; in_b = 16'h0F0F; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_op = 3'(ops3[k]); in_valid = 1'b1;
      tries = 0;
      do begin
        step();
        out_ready = ~out_ready;
        tries++;
      end while (!acc && tries < 8);
      if (!acc) begin
        chk_cnt++; err_cnt++;
        $display("FAIL mix_accept: got=timeout expected=accept for op %0d", ops3[k]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 6 && mq.size() != 0; t++) step();
    check_eq("mix_count", popped.size(), 5);
    for (int k = 0; k < 5 && k < popped.size(); k++) check_eq("mix_data", popped[k], e3[k]);

    // Reset mid-stream discards buffered results
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd7;
    in_a = 16'hAAAA; step();
    in_a = 16'hBBBB; step();
    reset = 1'b1; step();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("mrst_level", out_level, 0);
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_done", done_count, 0);
    popped.delete();
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("mrst_emitted", popped.size(), 0);

`ifdef LOGIC_UNIT_FLAGS_EN
    out_ready = 1'b0; in_valid = 1'b1;
    in_op = 3'd1; in_a = 16'h0F0F; in_b = 16'hF0F0; step();
    in_valid = 1'b0;
    check_eq("flg_data0", out_data, 16'h0000);
    check_eq("flg_zr0", out_zr, 1);
    check_eq("flg_ng0", out_ng, 0);
    out_ready = 1'b1; step();
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0001; step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("flg_data1", out_data, 16'hFFFE);
    check_eq("flg_zr1", out_zr, 0);
    check_eq("flg_ng1", out_ng, 1);
    out_ready = 1'b1; step();
    check_eq("flg_empty_ng", out_ng, 0);
`endif

    // Randomized traffic, honouring the hold-while-stalled rule
    pending = 1'b0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 3'($urandom);
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      pending = in_valid && !acc && !reset;
    end
    reset = 1'b0; in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
